output_sr_stream: RTL and testbench

//   Parametrised serial output shifter for driving external shift-register chips (74HC595 class).

---
 rtl/output_sr_stream.sv | 176 +++++++++++++++++
 tb/tb_output_sr_stream.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/output_sr_stream.sv
// Serial word shifter for 74HC595-class chains: valid/ready word input, one-deep hold, divided bit clock.
// Define OUTPUT_SR_STREAM_LATCH_EN to add a CLK_DIV-cycle latch strobe after every word.
module output_sr_stream #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CLK_DIV   = 1,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_bit,
  output logic             o_clk,
  output logic             o_latch,
  output logic             o_busy
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bit_q, bit_d;
  logic               clk_q, clk_d;
  logic               ready_q, busy_q;
  logic               accept;
  logic               load_en;
  logic [WIDTH-1:0]   load_word;
  logic               next_word;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign accept = i_valid & ready_q;

  // Next-state: phase/bit sequencing, hold register, word reload.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    clk_d       = clk_q;
    load_en     = 1'b0;
    load_word   = hold_q;
    next_word   = 1'b0;

    if (accept) begin
      hold_d      = i_data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          load_en     = 1'b1;
          hold_full_d = 1'b0;
        end else if (accept) begin
          load_en     = 1'b1;
          load_word   = i_data;
          hold_full_d = 1'b0;
        end
      end
      SHIFT: begin
        if (div_q != '0) begin
          div_d = div_q - DIV_W'(1);
        end else begin
          div_d = DIV_LOAD;
          if (!clk_q) begin
            clk_d = 1'b1;
          end else if (cnt_q == CNT_W'(1)) begin
`ifdef OUTPUT_SR_STREAM_LATCH_EN
            state_d = LATCH;
            clk_d   = 1'b0;
            bit_d   = 1'b0;
`else
            next_word = 1'b1;
`endif
          end else begin
            shreg_d = shift_one(shreg_q);
            bit_d   = head_bit(shift_one(shreg_q));
            cnt_d   = cnt_q - CNT_W'(1);
            clk_d   = 1'b0;
          end
        end
      end
      LATCH: begin
        if (div_q != '0) div_d = div_q - DIV_W'(1);
        else             next_word = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Hold is full only while o_ready is low, so no accept can collide with this reload.
    if (next_word) begin
      if (hold_full_q) begin
        load_en     = 1'b1;
        hold_full_d = 1'b0;
      end else begin
        state_d = IDLE;
        bit_d   = 1'b0;
        clk_d   = 1'b0;
      end
    end

    if (load_en) begin
      state_d = SHIFT;
      shreg_d = load_word;
      bit_d   = head_bit(load_word);
      cnt_d   = CNT_LOAD;
      div_d   = DIV_LOAD;
      clk_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      div_q       <= '0;
      cnt_q       <= '0;
      bit_q       <= 1'b0;
      clk_q       <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      clk_q       <= clk_d;
      ready_q     <= ~hold_full_d;
      busy_q      <= (state_d != IDLE) | hold_full_d;
    end
  end

`ifdef OUTPUT_SR_STREAM_LATCH_EN
  logic latch_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) latch_q <= 1'b0;
    else       latch_q <= (state_d == LATCH);
  end

  assign o_latch = latch_q;
`else
  assign o_latch = 1'b0;
`endif

  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign o_bit   = bit_q;
  assign o_clk   = clk_q;

endmodule

// File: tb/tb_output_sr_stream.sv
// Scoreboard bench for output_sr_stream: two instances (CLK_DIV=1 MSB-first, CLK_DIV=3 LSB-first).
module tb_output_sr_stream;

`ifdef OUTPUT_SR_STREAM_LATCH_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [1:0]      valid = '0;
  logic [1:0][7:0] data = '0;
  logic [1:0]      ready, obit, oclk, olatch, busy;

  int total = 0;
  int bad   = 0;
  int words_acc [2];
  bit exp_q [2][$];

  always #5 clk = ~clk;

  output_sr_stream #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_valid(valid[0]), .o_ready(ready[0]), .i_data(data[0]),
    .o_bit(obit[0]), .o_clk(oclk[0]), .o_latch(olatch[0]), .o_busy(busy[0]));

  output_sr_stream #(.WIDTH(8), .CLK_DIV(3), .MSB_FIRST(0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_valid(valid[1]), .o_ready(ready[1]), .i_data(data[1]),
    .o_bit(obit[1]), .o_clk(oclk[1]), .o_latch(olatch[1]), .o_busy(busy[1]));

  function automatic bit msb_of(int i);
    return (i == 0);
  endfunction

  function automatic int div_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one instance's inputs; a word presented while ready is accepted at the next edge.
  task automatic drive(int i, logic v, logic [7:0] d);
    valid[i] = v;
    data[i]  = d;
    if (v && ready[i]) begin
      words_acc[i]++;
      for (int b = 0; b < 8; b++) exp_q[i].push_back(msb_of(i) ? d[7-b] : d[b]);
    end
  endtask

  task automatic chk_reset(int i, string tag);
    chk({tag, "_bit"},   int'(obit[i]),   0);
    chk({tag, "_clk"},   int'(oclk[i]),   0);
    chk({tag, "_latch"}, int'(olatch[i]), 0);
    chk({tag, "_busy"},  int'(busy[i]),   0);
    chk({tag, "_ready"}, int'(ready[i]),  1);
  endtask

  // Single word from idle: first-bit latency, first rise, and total busy time.
  task automatic timed_word(int i, logic [7:0] d, string tag);
    int fr = -1;
    int ik = -1;
    logic pc = 1'b0;
    @(negedge clk);
    drive(i, 1'b1, d);
    for (int k = 0; k < 200 && ik < 0; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk({tag, "_first_bit"}, int'(obit[i]), int'(msb_of(i) ? d[7] : d[0]));
        chk({tag, "_clk_low0"}, int'(oclk[i]), 0);
        drive(i, 1'b0, 8'($urandom));
      end
      if (oclk[i] && !pc && fr < 0) fr = k;
      if (!busy[i]) ik = k;
      pc = oclk[i];
    end
    chk({tag, "_first_rise"}, fr, div_of(i));
    chk({tag, "_idle_after"}, ik, 16 * div_of(i) + LAT * div_of(i));
  endtask

  // Per-instance monitor: pops the scoreboard on every o_clk rise, checks phase and latch shapes.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic pclk = 1'b0;
    logic pbit = 1'b0;
    int hi_len = 0;
    int lat_len = 0;
    int rises = 0;
    int lat_pulses = 0;

    always @(negedge clk) begin
      pclk <= oclk[g];
      pbit <= obit[g];
      if (rst) begin
        hi_len     <= 0;
        lat_len    <= 0;
        rises      <= 0;
        lat_pulses <= 0;
      end else begin
        hi_len  <= oclk[g] ? hi_len + 1 : 0;
        lat_len <= olatch[g] ? lat_len + 1 : 0;
        if (oclk[g] && !pclk) begin
          rises <= rises + 1;
          if (exp_q[g].size() == 0) chk($sformatf("extra_rise%0d", g), 1, 0);
          else chk($sformatf("bit%0d_rise%0d", g, rises), int'(obit[g]), int'(exp_q[g].pop_front()));
        end
        if (oclk[g] && pclk) chk($sformatf("bit_stable_hi%0d", g), int'(obit[g]), int'(pbit));
        if (!oclk[g] && pclk) chk($sformatf("hi_len%0d", g), hi_len, div_of(g));
        if (olatch[g]) chk($sformatf("latch_clk_low%0d", g), int'(oclk[g]), 0);
        if (olatch[g] && lat_len == 0) begin
          lat_pulses <= lat_pulses + 1;
          chk($sformatf("latch_after_hi%0d", g), int'(pclk), 1);
          chk($sformatf("latch_word_end%0d", g), rises % 8, 0);
        end
        if (!olatch[g] && lat_len != 0) chk($sformatf("latch_len%0d", g), lat_len, div_of(g));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int fr, lr, nr, rk, edges, n;
    logic pc, pr;
    words_acc[0] = 0;
    words_acc[1] = 0;

    #1 rst = 1'b1;
    #1 chk_reset(0, "rst0");
    chk_reset(1, "rst1");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready0", int'(ready[0]), 1);
    chk("post_rst_busy1", int'(busy[1]), 0);

    // 0xA5 MSB-first at CLK_DIV=1, then 0x01 LSB-first at CLK_DIV=3
    timed_word(0, 8'hA5, "a5");
    timed_word(1, 8'h01, "x01");
    timed_word(1, 8'hB6, "xb6");

    // Back-to-back: second word lands in hold and reloads with no gap
    fr = -1; lr = -1; nr = 0; rk = -1; pc = 1'b0; pr = 1'b1;
    @(negedge clk);
    drive(0, 1'b1, 8'hFF);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (oclk[0] && !pc) begin
        nr++;
        if (fr < 0) fr = k;
        lr = k;
      end
      if (ready[0] && !pr && rk < 0) rk = k;
      pc = oclk[0];
      pr = ready[0];
      if (k == 0) begin
        chk("b2b_ready_first", int'(ready[0]), 1);
        drive(0, 1'b1, 8'h00);
      end else if (k == 1) begin
        chk("b2b_ready_low", int'(ready[0]), 0);
        chk("b2b_busy", int'(busy[0]), 1);
        drive(0, 1'b0, 8'h5A);
      end
    end
    chk("b2b_rises", nr, 16);
    chk("b2b_first_rise", fr, 1);
    chk("b2b_span", lr - fr, 30 + LAT);
    chk("b2b_ready_back", rk, 16 + LAT);
    chk("b2b_idle", int'(busy[0]), 0);

    // Reset in the middle of the third bit with a word also held
    @(negedge clk);
    drive(1, 1'b1, 8'hFF);
    @(negedge clk);
    drive(1, 1'b1, 8'hC3);
    @(negedge clk);
    drive(1, 1'b0, 8'h00);
    repeat (14) @(negedge clk);
    chk("mid_pre_clk", int'(oclk[1]), 1);
    chk("mid_pre_bit", int'(obit[1]), 1);
    #2 rst = 1'b1;
    exp_q[0].delete();
    exp_q[1].delete();
    words_acc[0] = 0;
    words_acc[1] = 0;
    #1 chk_reset(1, "mid_rst");
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    edges = 0;
    pc = oclk[1];
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (oclk[1] != pc) edges++;
      pc = oclk[1];
    end
    chk("mid_after_ready", int'(ready[1]), 1);
    chk("mid_after_busy", int'(busy[1]), 0);
    chk("mid_after_edges", edges, 0);

    // Random traffic with random valid gaps and junk data while not ready
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) drive(i, 1'($urandom_range(0, 3) == 0), 8'($urandom));
    end
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    n = 0;
    while ((busy != 2'b00) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_idle", int'(busy), 0);
    repeat (4) @(negedge clk);
    chk("drain_q0", exp_q[0].size(), 0);
    chk("drain_q1", exp_q[1].size(), 0);
    chk("latch_pulses0", g_mon[0].lat_pulses, LAT * words_acc[0]);
    chk("latch_pulses1", g_mon[1].lat_pulses, LAT * words_acc[1]);
    chk("end_ready", int'(ready), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
